// File: rtl/data_mem_ctrl.sv
// Data memory for the memory stage: single/double-word accesses behind a
// valid/ready port, registered reads, and a zero-fill sweep after reset.
module data_mem_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int ADDR_W         = 11,
  parameter int DOUBLE_EN      = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_double,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [2*WORD_SIZE-1:0] wd,
  output logic [2*WORD_SIZE-1:0] rd,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   addr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;
  localparam logic [1:0] S_RST    = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [WORD_SIZE-1:0]   mem [DEPTH];

  logic [1:0]             state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic                   started_q;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wlo_q, wlo_d;
  logic                   wr_q, wr_d;
  logic [WORD_SIZE-1:0]   hi_q, hi_d;
  logic [2*WORD_SIZE-1:0] rd_q, rd_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_q, err_d;

  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr, mem_raddr, addr2;
  logic [WORD_SIZE-1:0]   mem_wdata, rword;
  logic                   accept, dbl;

  // started_q holds off req_ready for the first cycle after release when
  // there is no clear sweep to do it.
  assign req_ready = started_q && (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign rd        = rd_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = err_q;

  assign accept = req_valid && req_ready;
  assign dbl    = (DOUBLE_EN != 0) && req_double;
  assign addr2  = addr_q + ADDR_W'(1);
  assign rword  = mem[mem_raddr];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wlo_d      = wlo_q;
    wr_d       = wr_q;
    hi_d       = hi_q;
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cnt_q;
    mem_wdata  = '0;
    mem_raddr  = addr;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          addr_d = addr;
          wlo_d  = wd[WORD_SIZE-1:0];
          wr_d   = req_write;
          if (req_write) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = dbl ? wd[2*WORD_SIZE-1:WORD_SIZE] : wd[WORD_SIZE-1:0];
          end else if (dbl) begin
            hi_d = rword;
          end else begin
            rd_d       = {{WORD_SIZE{1'b0}}, rword};
            rd_valid_d = 1'b1;
          end
          if (dbl) state_d = S_SECOND;
        end
      end
      S_SECOND: begin
        // Second beat uses only latched request fields; the port is ignored.
        mem_raddr = addr2;
        if (wr_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr2;
          mem_wdata = wlo_q;
        end else begin
          rd_d       = {hi_q, rword};
          rd_valid_d = 1'b1;
        end
        err_d   = (addr_q == '1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RST;
      cnt_q      <= '0;
      started_q  <= 1'b0;
      addr_q     <= '0;
      wlo_q      <= '0;
      wr_q       <= 1'b0;
      hi_q       <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      started_q  <= 1'b1;
      addr_q     <= addr_d;
      wlo_q      <= wlo_d;
      wr_q       <= wr_d;
      hi_q       <= hi_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; a reset mid-access simply drops the pending beat.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Next-generation data memory for the pipeline's memory stage. It holds a parametrised word array behind a valid/ready request port. It supports single-word and double-word accesses; double-word is used for 32-bit PC/flag push/pop. It also runs a hardware clear sequence after reset, since the array is not reset asynchronously. Reads are registered, and the block stalls the pipeline through req_ready/busy.

Parameters:
WORD_SIZE, 16, bits per memory word
ADDR_W, 11, address width; array depth is 2**ADDR_W words
DOUBLE_EN, 1, 1 enables double-word access; 0 treats req_double as 0
CLEAR_ON_RESET, 1, 1 runs the zero-fill sequence after reset release; 0 goes straight to IDLE

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  access request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_double  input  1  1 = two-word access (addr, addr+1)
addr  input  ADDR_W  word address of first word
wd  input  2*WORD_SIZE  write data; single access uses [WORD_SIZE-1:0]
rd  output  2*WORD_SIZE  registered read data
rd_valid  output  1  one-cycle pulse: rd holds completed read
busy  output  1  clear sequence or second beat in progress
addr_err  output  1  one-cycle pulse with completion when a double access wrapped past the top address

Behaviour:
- Reset (rst low, asynchronous): state=CLEAR if CLEAR_ON_RESET else IDLE; clear counter=0; req_ready=0, busy=1, rd=0, rd_valid=0, addr_err=0. Array contents are not touched by reset.
- Reset asserted mid-access or mid-clear aborts the operation. A partially completed double write leaves only the first word written.
- States: CLEAR, IDLE, SECOND.
- CLEAR: one word/cycle, mem[cnt]<=0, cnt++. Exits to IDLE after writing index 2**ADDR_W-1, i.e. 2**ADDR_W cycles after the first rising edge with rst high. req_ready=0, busy=1 throughout.
- CLEAR_ON_RESET=0: first edge after release enters IDLE. req_ready=1 from the following cycle.
- IDLE: req_ready=1, busy=0. Acceptance = req_valid & req_ready on a rising edge.
- Single write: mem[addr]<=wd[WORD_SIZE-1:0] at the accepting edge. No rd_valid pulse.
- Single read: at the accepting edge, rd<={WORD_SIZE'b0, mem[addr]} and rd_valid=1 for the next cycle (latency 1).
- Double access (DOUBLE_EN=1, req_double=1): word at addr is the high half, addr+1 the low half.
  - Beat 1 at the accepting edge: write mem[addr]<=wd[2W-1:W], or latch mem[addr] into the high half.
  - Block latches addr, wd and the op, then goes to SECOND. In SECOND, req_ready=0 and busy=1.
  - Beat 2 at the next edge: access (addr+1) mod 2**ADDR_W, write mem[addr+1]<=wd[W-1:0], or latch into the low half.
  - Returns to IDLE. Read completion: rd = full 32-bit value, rd_valid=1 for one cycle after beat 2 (latency 2).
- Wrap: double access at addr=2**ADDR_W-1 uses word 0 as the second beat. addr_err pulses in the completion cycle, for reads and writes alike.
- Inputs are sampled only at acceptance. Changes to addr/wd while in SECOND are ignored.
- Back-to-back single accesses are accepted every cycle. A read following a write to the same address returns the new data.
- rd holds its value until the next read completes. rd_valid and addr_err are single-cycle pulses.
- Writes never drive rd.

Test Plan:
- ADDR_W=4, CLEAR_ON_RESET=1: preload garbage via writes, pulse rst low → req_ready=0 for exactly 16 cycles after release, then reads of all 16 addresses return 0.
- Single write addr=3 wd=0x0000_BEEF, next cycle read addr=3 → rd=0x0000_BEEF, rd_valid high for exactly one cycle after acceptance.
- Double write addr=6 wd=0x1234_5678 → req_ready low one cycle. Single reads give mem[6]=0x1234 and mem[7]=0x5678. Double read addr=6 → rd=0x1234_5678 two cycles after acceptance.
- Double write at addr=15 wd=0xAAAA_5555 → addr_err pulse; mem[15]=0xAAAA, mem[0]=0x5555.
- Assert rst low while in SECOND of a double write to addr=8 → outputs reset immediately; after the clear sequence, mem[8]=0 and mem[9]=0.
- DOUBLE_EN=0, req_double=1 read at addr=2 → treated as single; rd upper half=0, latency 1, req_ready never drops.
